pipeline_exec_control: RTL and testbench
========================================

Name: pipeline_exec_control

Overview:
Execution sequencer for the 5-stage MIPS pipeline. It sits between the debug unit command path and the pipeline-wide stage enable and flush lines. It runs the pipeline continuously or one clock at a time. When the halt instruction is detected, it drains the remaining in-flight stages, then parks the pipeline and reports completion and the number of clocks executed.

Parameters:
PIPE_DEPTH, 5, number of pipeline stages; drain length after halt detection = PIPE_DEPTH-1 enabled cycles
CYCLE_CNT_SIZE, 32, width of the executed-cycle counter

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_cmd_valid  input  1  command present on i_cmd
i_cmd  input  2  00 NOP, 01 RUN, 10 STEP, 11 ABORT
o_cmd_ready  output  1  controller can accept a command this cycle
i_halt  input  1  halt opcode detected in ID; sampled only while o_pipe_enable=1
o_pipe_enable  output  1  global stage enable (PC and all pipeline registers)
o_pipe_flush  output  1  one-cycle clear of all pipeline registers and PC
o_done  output  1  one-cycle pulse: step finished or drain finished
o_halted  output  1  level, pipeline parked after halt
o_busy  output  1  high in RUN, STEP, DRAIN, FLUSH
o_cycle_count  output  CYCLE_CNT_SIZE  number of cycles with o_pipe_enable=1 since last ABORT/reset

Behaviour:
- Reset (synchronous, overrides everything, including mid-RUN and mid-DRAIN):
  - state=IDLE; drain counter=0; o_cycle_count=0.
  - o_pipe_enable=0, o_pipe_flush=0, o_done=0, o_halted=0, o_busy=0, o_cmd_ready=1.
- Handshake:
  - A command is accepted on an edge where i_cmd_valid & o_cmd_ready.
  - NOP, or a command not legal in the current state, is accepted and dropped with no effect.
  - Accepted at edge N, the response (enable/flush) is visible in the cycle after edge N.
- Output timing: o_pipe_enable, o_pipe_flush, o_halted and o_busy are decoded from the registered state (Moore). o_done is a registered pulse.
- States:
  - IDLE: enable=0, ready=1.
    - RUN -> RUN.
    - STEP -> STEP.
    - ABORT -> FLUSH.
  - RUN: enable=1, ready=1 (only ABORT acts).
    - ABORT -> FLUSH; ABORT has priority over a same-cycle i_halt.
    - Else i_halt=1 -> DRAIN, drain counter loaded with PIPE_DEPTH-1.
  - STEP: enable=1 for exactly one cycle, ready=0.
    - i_halt=1 -> DRAIN, loaded as above.
    - Else -> IDLE, with o_done=1 in the first IDLE cycle.
  - DRAIN: enable=1, ready=0; ABORT is not accepted.
    - Counter decrements each cycle.
    - In the cycle the counter equals 1 -> HALTED, with o_done=1 in the first HALTED cycle.
    - A drain entered from STEP still runs all PIPE_DEPTH-1 cycles continuously.
    - i_halt is ignored while in DRAIN.
  - HALTED: enable=0, o_halted=1, ready=1.
    - ABORT -> FLUSH.
    - RUN and STEP are dropped.
  - FLUSH: flush=1, enable=0, ready=0, for one cycle.
    - -> IDLE; o_cycle_count cleared to 0 at the same edge.
- Cycle counter:
  - +1 at every edge where o_pipe_enable=1 (RUN, STEP, DRAIN).
  - Saturates at all ones; no wrap.
  - Holds in IDLE and HALTED.
- i_halt is ignored in IDLE, HALTED and FLUSH.
- PIPE_DEPTH=1 means zero drain: i_halt goes directly to HALTED.
- o_done never asserts on ABORT.

Test Plan:
1. Reset held 2 cycles, then released -> all outputs 0 except o_cmd_ready=1; o_cycle_count=0; state IDLE.
2. Three STEP commands, each issued once o_cmd_ready=1 -> each gives exactly one o_pipe_enable cycle, then o_done pulse; o_cycle_count=3; o_halted=0.
3. RUN; i_halt=1 for one cycle in the 10th enabled cycle (PIPE_DEPTH=5):
   - 4 further enable cycles, then o_done pulse and o_halted=1.
   - o_cycle_count=14; RUN/STEP in HALTED have no effect.
4. From HALTED, ABORT -> one cycle o_pipe_flush=1 with o_pipe_enable=0; then IDLE, o_cycle_count=0, o_halted=0, no o_done.
5. RUN, then ABORT valid in the same cycle as i_halt=1 -> FLUSH taken, no DRAIN, no o_done.
6. i_reset asserted during 2nd DRAIN cycle -> next cycle IDLE with all reset values, o_cycle_count=0; no o_done afterwards. Saturation check with CYCLE_CNT_SIZE=4: 20 RUN cycles -> o_cycle_count=15.

Source files
------------

// File: rtl/pipeline_exec_control.sv
// pipeline_exec_control
//   Execution sequencer for the 5-stage MIPS pipeline. It takes RUN, STEP and
//   ABORT commands from the debug unit and drives the pipeline-wide stage
//   enable and flush lines. A halt opcode seen in ID starts a drain of the
//   remaining in-flight stages. After the drain the pipeline is parked, o_done
//   pulses once, and o_cycle_count reports how many clocks were executed.
//
// Ports
//   i_clk, i_reset   clock; synchronous active-high reset
//   i_cmd_valid      command present on i_cmd
//   i_cmd            00 NOP, 01 RUN, 10 STEP, 11 ABORT
//   o_cmd_ready      command can be accepted this cycle
//   i_halt           halt opcode in ID; only looked at in RUN/STEP
//   o_pipe_enable    global stage enable
//   o_pipe_flush     one-cycle clear of pipeline registers and PC
//   o_done           one-cycle pulse: step finished or drain finished
//   o_halted         level: parked after halt
//   o_busy           high in RUN, STEP, DRAIN, FLUSH
//   o_cycle_count    enabled cycles since last ABORT/reset, saturating
module pipeline_exec_control #(
  parameter int PIPE_DEPTH     = 5,
  parameter int CYCLE_CNT_SIZE = 32
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_cmd_valid,
  input  logic [1:0]                i_cmd,
  output logic                      o_cmd_ready,
  input  logic                      i_halt,
  output logic                      o_pipe_enable,
  output logic                      o_pipe_flush,
  output logic                      o_done,
  output logic                      o_halted,
  output logic                      o_busy,
  output logic [CYCLE_CNT_SIZE-1:0] o_cycle_count
);

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
  localparam logic [2:0] S_FLUSH  = 3'd5;

  localparam int          DW       = $clog2(PIPE_DEPTH + 1);
  localparam logic [DW-1:0] DRAIN_LD = DW'(PIPE_DEPTH - 1);
  localparam logic [DW-1:0] DRAIN_ONE = DW'(1);

  logic [2:0]    r_state, w_state_nxt;
  logic [DW-1:0] r_drain, w_drain_nxt;
  logic          r_done,  w_done_nxt;
  logic          w_accept;

  assign w_accept = i_cmd_valid & o_cmd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (i_cmd)
            CMD_RUN:   w_state_nxt = S_RUN;
            CMD_STEP:  w_state_nxt = S_STEP;
            CMD_ABORT: w_state_nxt = S_FLUSH;
            default:   w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        // ABORT only reaches here from RUN (ready is low in STEP) and wins
        // over a halt seen in the same cycle.
        if (w_accept && i_cmd == CMD_ABORT) begin
          w_state_nxt = S_FLUSH;
        end else if (i_halt) begin
          // Single-stage pipeline has nothing in flight: park immediately.
          if (PIPE_DEPTH <= 1) begin
            w_state_nxt = S_HALTED;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = DRAIN_LD;
          end
        end else if (r_state == S_STEP) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      S_DRAIN: begin
        w_drain_nxt = r_drain - 1'b1;
        if (r_drain == DRAIN_ONE) begin
          w_state_nxt = S_HALTED;
          w_done_nxt  = 1'b1;
        end
      end
      S_HALTED: begin
        if (w_accept && i_cmd == CMD_ABORT) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_drain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Counter clears on the FLUSH->IDLE edge; saturates rather than wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset || r_state == S_FLUSH) begin
      o_cycle_count <= '0;
    end else if (o_pipe_enable && o_cycle_count != '1) begin
      o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

  assign o_pipe_enable = (r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN);
  assign o_pipe_flush  = (r_state == S_FLUSH);
  assign o_halted      = (r_state == S_HALTED);
  assign o_busy        = o_pipe_enable || o_pipe_flush;
  assign o_cmd_ready   = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_HALTED);
  assign o_done        = r_done;

endmodule

// File: tb/tb_pipeline_exec_control.sv
module tb_pipeline_exec_control;

  localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, ABORT = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        a_v = 1'b0, a_h = 1'b0;
  logic [1:0]  a_cmd = NOP;
  logic        a_rdy, a_en, a_fl, a_dn, a_hl, a_bs;
  logic [31:0] a_cnt;

  // DUT B: 4-bit counter for saturation
  logic        b_v = 1'b0, b_h = 1'b0;
  logic [1:0]  b_cmd = NOP;
  logic        b_rdy, b_en, b_fl, b_dn, b_hl, b_bs;
  logic [3:0]  b_cnt;

  pipeline_exec_control dut_a (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(a_v), .i_cmd(a_cmd),
    .o_cmd_ready(a_rdy), .i_halt(a_h), .o_pipe_enable(a_en),
    .o_pipe_flush(a_fl), .o_done(a_dn), .o_halted(a_hl), .o_busy(a_bs),
    .o_cycle_count(a_cnt));

  pipeline_exec_control #(.PIPE_DEPTH(5), .CYCLE_CNT_SIZE(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(b_v), .i_cmd(b_cmd),
    .o_cmd_ready(b_rdy), .i_halt(b_h), .o_pipe_enable(b_en),
    .o_pipe_flush(b_fl), .o_done(b_dn), .o_halted(b_hl), .o_busy(b_bs),
    .o_cycle_count(b_cnt));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  always @(negedge clk) if (!rst && a_dn) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {enable, flush, done, halted, busy, ready}
  task automatic chk_outs(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, a_en, a_fl, a_dn, a_hl, a_bs, a_rdy}, {26'd0, exp});
  endtask

  task automatic issue_a(input logic [1:0] c);
    a_v = 1'b1; a_cmd = c;
    tick();
    a_v = 1'b0; a_cmd = NOP;
  endtask

  // Counts enabled cycles until o_done is seen, bounded.
  task automatic run_until_done(output int en_cnt, output logic seen);
    en_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (a_dn) begin seen = 1'b1; break; end
      if (a_en) en_cnt++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  int   en_cnt;
  logic seen;
  int   dn_snap;

  initial begin
    // 1. reset
    do_reset();
    chk_outs("reset_outs", 6'b000001);
    chk("reset_cnt", a_cnt, 32'd0);

    // 2. three single steps
    for (int s = 1; s <= 3; s++) begin
      chk("step_ready", {31'd0, a_rdy}, 32'd1);
      issue_a(STEP);
      exp_q.push_back(s);
      chk_outs("step_active", 6'b100010);
      run_until_done(en_cnt, seen);
      chk("step_done_seen", {31'd0, seen}, 32'd1);
      chk("step_en_cycles", en_cnt, 32'd1);
      chk("step_cnt", a_cnt, exp_q.pop_front());
      chk("step_halted", {31'd0, a_hl}, 32'd0);
    end
    tick();
    chk("step_done_total", done_cnt, 32'd3);

    // 3. run, halt in 10th enabled cycle, drain 4
    do_reset();
    issue_a(RUN);
    exp_q.push_back(32'd14);
    chk_outs("run_active", 6'b100011);
    for (int i = 0; i < 9; i++) tick();
    a_h = 1'b1;
    tick();
    a_h = 1'b0;
    chk("run_cnt_at_halt", a_cnt, 32'd10);
    chk_outs("drain_outs", 6'b100010);
    run_until_done(en_cnt, seen);
    chk("drain_done_seen", {31'd0, seen}, 32'd1);
    chk("drain_en_cycles", en_cnt, 32'd4);
    chk("drain_cnt", a_cnt, exp_q.pop_front());
    chk_outs("halted_outs", 6'b001101);
    issue_a(RUN);
    chk_outs("halted_run_dropped", 6'b000101);
    issue_a(STEP);
    chk_outs("halted_step_dropped", 6'b000101);
    chk("halted_cnt_hold", a_cnt, 32'd14);
    chk("drain_done_total", done_cnt, 32'd4);

    // 4. abort from halted
    issue_a(ABORT);
    exp_q.push_back(32'd0);
    chk_outs("flush_outs", 6'b010010);
    tick();
    chk_outs("post_flush_idle", 6'b000001);
    chk("post_flush_cnt", a_cnt, exp_q.pop_front());
    tick();
    chk("abort_no_done", done_cnt, 32'd4);

    // 5. abort in same cycle as halt
    issue_a(RUN);
    tick(); tick();
    a_v = 1'b1; a_cmd = ABORT; a_h = 1'b1;
    tick();
    a_v = 1'b0; a_cmd = NOP; a_h = 1'b0;
    chk_outs("abort_prio_flush", 6'b010010);
    tick();
    chk_outs("abort_prio_idle", 6'b000001);
    chk("abort_prio_cnt", a_cnt, 32'd0);
    tick(); tick();
    chk("abort_prio_no_done", done_cnt, 32'd4);

    // 6. reset during 2nd drain cycle
    issue_a(RUN);
    a_h = 1'b1;
    tick();
    a_h = 1'b0;
    chk_outs("drain1_outs", 6'b100010);
    tick();
    chk_outs("drain2_outs", 6'b100010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs("mid_drain_reset_outs", 6'b000001);
    chk("mid_drain_reset_cnt", a_cnt, 32'd0);
    dn_snap = done_cnt;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_drain_no_done", done_cnt, dn_snap);
    chk_outs("mid_drain_idle", 6'b000001);

    // saturation on 4-bit counter
    b_v = 1'b1; b_cmd = RUN;
    tick();
    b_v = 1'b0; b_cmd = NOP;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_cnt_14", {28'd0, b_cnt}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_cnt_20", {28'd0, b_cnt}, 32'd15);
    chk("sat_still_run", {31'd0, b_en}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
